// File: rtl/uart_rx_filt.sv
// uart_rx_filt: 8N1 UART receiver with a 16x oversampling FSM, selectable baud
// divider and a ready/valid output register that reports overruns.
//
// Optional feature: define UART_RX_FILTER_EN to insert a 3-tap majority-vote
// glitch filter between the input synchronizer and the FSM (adds 2 clocks of
// latency). Without the macro the synchronizer feeds the FSM directly.
//
// Ports:
//   clk_i        in   1  system clock, rising edge
//   rst_i        in   1  synchronous active-high reset
//   rate_i       in   2  baud select: 0=BAUDRATE, 1=/2, 2=/4, 3=/8
//   rxd_i        in   1  asynchronous serial line, idle high, LSB first
//   data_o       out  8  received byte
//   data_valid_o out  1  data_o holds a valid byte
//   ready_i      in   1  consumer accepts data_o
//   frame_err_o  out  1  one-cycle pulse, stop bit sampled low
//   overrun_o    out  1  one-cycle pulse, completed byte dropped
//   busy_o       out  1  FSM is not in IDLE
module uart_rx_filt #(
  parameter int unsigned FREQ     = 100_000_000,
  parameter int unsigned BAUDRATE = 921_600
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] rate_i,
  input  logic       rxd_i,
  output logic [7:0] data_o,
  output logic       data_valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       busy_o
);

  // Rounded clocks per oversample tick at the base rate
  localparam int unsigned DIV_BASE = (FREQ + 8 * BAUDRATE) / (16 * BAUDRATE);
  localparam int unsigned CNT_W    = $clog2(DIV_BASE * 8 + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state_q, state_d;
  logic [1:0]         sync_q;
  logic               line_c;
  logic               line_prev_q;
  logic [1:0]         rate_q;
  logic [CNT_W-1:0]   tick_cnt_q;
  logic [CNT_W-1:0]   div_c;
  logic               tick_c;
  logic [3:0]         tick_num_q;
  logic [2:0]         bit_cnt_q;
  logic [7:0]         shift_q;
  logic               err_wait_q;

  logic               start_c;
  logic               mid_c;
  logic               bit_c;
  logic               stop_c;
  logic               byte_done_c;
  logic               frame_err_c;

  // Two-flop synchronizer, idles high
  always_ff @(posedge clk_i) begin
    if (rst_i) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], rxd_i};
  end

`ifdef UART_RX_FILTER_EN
  logic [2:0] filt_q;

  // Majority of three consecutive samples rejects single-cycle glitches
  always_ff @(posedge clk_i) begin
    if (rst_i) filt_q <= 3'b111;
    else       filt_q <= {filt_q[1:0], sync_q[1]};
  end

  assign line_c = (filt_q[0] & filt_q[1]) | (filt_q[0] & filt_q[2]) |
                  (filt_q[1] & filt_q[2]);
`else
  assign line_c = sync_q[1];
`endif

  // Oversample tick period scales with the rate latched at frame start
  assign div_c  = CNT_W'(DIV_BASE << rate_q);
  assign tick_c = (tick_cnt_q == div_c - CNT_W'(1));

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (line_prev_q && !line_c) state_d = START;
      START: if (tick_c && tick_num_q == 4'd7) state_d = line_c ? IDLE : DATA;
      DATA:  if (tick_c && tick_num_q == 4'd15 && bit_cnt_q == 3'd7) state_d = STOP;
      STOP: begin
        if (err_wait_q) begin
          // After a framing error, leave only once the line is seen high on a tick
          if (tick_c && line_c) state_d = IDLE;
        end else if (tick_c && tick_num_q == 4'd15 && line_c) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output/strobe decode
  always_comb begin
    start_c     = 1'b0;
    mid_c       = 1'b0;
    bit_c       = 1'b0;
    stop_c      = 1'b0;
    byte_done_c = 1'b0;
    frame_err_c = 1'b0;
    case (state_q)
      IDLE:  start_c = line_prev_q && !line_c;
      START: mid_c   = tick_c && (tick_num_q == 4'd7);
      DATA:  bit_c   = tick_c && (tick_num_q == 4'd15);
      STOP:  stop_c  = !err_wait_q && tick_c && (tick_num_q == 4'd15);
      default: ;
    endcase
    byte_done_c = stop_c && line_c;
    frame_err_c = stop_c && !line_c;
  end

  // Receive datapath: edge history, rate latch, tick and bit counters, shifter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      line_prev_q <= 1'b1;
      rate_q      <= 2'd0;
      tick_cnt_q  <= '0;
      tick_num_q  <= 4'd0;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'd0;
      err_wait_q  <= 1'b0;
    end else begin
      line_prev_q <= line_c;

      if (state_q == IDLE) rate_q <= rate_i;

      if (state_q == IDLE || start_c || tick_c) tick_cnt_q <= '0;
      else                                      tick_cnt_q <= tick_cnt_q + CNT_W'(1);

      if (state_q == IDLE)   tick_num_q <= 4'd0;
      else if (mid_c)        tick_num_q <= 4'd0;
      else if (tick_c)       tick_num_q <= tick_num_q + 4'd1;

      if (state_q == IDLE)   bit_cnt_q <= 3'd0;
      else if (bit_c)        bit_cnt_q <= bit_cnt_q + 3'd1;

      if (bit_c) shift_q <= {line_c, shift_q[7:1]};

      if (state_d == IDLE)   err_wait_q <= 1'b0;
      else if (frame_err_c)  err_wait_q <= 1'b1;
    end
  end

  // Registered outputs with ready/valid hold and overrun detection
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_o       <= 8'd0;
      data_valid_o <= 1'b0;
      frame_err_o  <= 1'b0;
      overrun_o    <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      if (byte_done_c && (!data_valid_o || ready_i)) begin
        data_o       <= shift_q;
        data_valid_o <= 1'b1;
      end else if (data_valid_o && ready_i) begin
        data_valid_o <= 1'b0;
      end
      overrun_o   <= byte_done_c && data_valid_o && !ready_i;
      frame_err_o <= frame_err_c;
      busy_o      <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_rx_filt.sv
// tb_uart_rx_filt: directed frames with a scoreboard; expected bytes are queued
// by the stimulus and popped by a negedge monitor on each output handshake.
module tb_uart_rx_filt;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [1:0] rate_i;
  logic       rxd_i;
  logic [7:0] data_o;
  logic       data_valid_o;
  logic       ready_i;
  logic       frame_err_o;
  logic       overrun_o;
  logic       busy_o;

  uart_rx_filt dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .rate_i      (rate_i),
    .rxd_i       (rxd_i),
    .data_o      (data_o),
    .data_valid_o(data_valid_o),
    .ready_i     (ready_i),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  localparam int BIT0 = 112;  // clocks per bit at rate 0
  localparam int BIT3 = 896;  // clocks per bit at rate 3

  logic [7:0] exp_q[$];
  int n_cmp = 0;
  int n_mis = 0;
  int fe_cnt = 0, ov_cnt = 0, vcyc = 0, busy_cyc = 0;
  logic fe_prev = 1'b0, ov_prev = 1'b0;
  logic [7:0] exp_b;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: scoreboard pops on handshake, pulse counters and width checks
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (data_valid_o) vcyc++;
      if (busy_o) busy_cyc++;
      if (data_valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_mis++;
          $display("FAIL unexpected_byte: got 0x%02h, expected no byte", data_o);
        end else begin
          exp_b = exp_q.pop_front();
          check("rx_byte", int'(data_o), int'(exp_b));
        end
      end
      if (frame_err_o) begin
        fe_cnt++;
        check("frame_err_width", int'(fe_prev), 0);
      end
      if (overrun_o) begin
        ov_cnt++;
        check("overrun_width", int'(ov_prev), 0);
      end
    end
    fe_prev = frame_err_o;
    ov_prev = overrun_o;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop, input int bclk);
    rxd_i = 1'b0;
    tick(bclk);
    for (int i = 0; i < 8; i++) begin
      rxd_i = d[i];
      tick(bclk);
    end
    rxd_i = stop;
    tick(bclk);
    rxd_i = 1'b1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_data"},  int'(data_o), 0);
    check({tag, "_valid"}, int'(data_valid_o), 0);
    check({tag, "_ferr"},  int'(frame_err_o), 0);
    check({tag, "_ovr"},   int'(overrun_o), 0);
    check({tag, "_busy"},  int'(busy_o), 0);
  endtask

  int v0, f0, o0, b0;

  initial begin
    rst_i   = 1'b1;
    rate_i  = 2'd0;
    rxd_i   = 1'b1;
    ready_i = 1'b1;
    tick(3);
    check_quiet("reset");
    rst_i = 1'b0;
    tick(20);

    // Single byte, always-ready consumer
    v0 = vcyc; f0 = fe_cnt; o0 = ov_cnt;
    exp_q.push_back(8'h0F);
    send_byte(8'h0F, 1'b1, BIT0);
    tick(2 * BIT0);
    check("valid_cycles_0f", vcyc - v0, 1);
    check("ferr_0f", fe_cnt - f0, 0);
    check("ovr_0f", ov_cnt - o0, 0);

`ifdef UART_RX_FILTER_EN
    // Single-cycle glitches must never start a frame
    b0 = busy_cyc;
    for (int i = 0; i < 10; i++) begin
      rxd_i = 1'b0;
      tick(1);
      rxd_i = 1'b1;
      tick(20);
    end
    tick(20);
    check("glitch_busy_cycles", busy_cyc - b0, 0);
`endif

    // Short low pulse is a false start: busy briefly, no byte
    b0 = busy_cyc; v0 = vcyc;
    rxd_i = 1'b0;
    tick(30);
    rxd_i = 1'b1;
    tick(200);
    check("false_start_busy_seen", int'(busy_cyc - b0 > 0), 1);
    check("false_start_busy_end", int'(busy_o), 0);
    check("false_start_no_valid", vcyc - v0, 0);

    // Framing error then recovery
    f0 = fe_cnt; v0 = vcyc;
    send_byte(8'hA5, 1'b0, BIT0);
    tick(2 * BIT0);
    check("ferr_count", fe_cnt - f0, 1);
    check("ferr_no_valid", vcyc - v0, 0);
    exp_q.push_back(8'h5A);
    send_byte(8'h5A, 1'b1, BIT0);
    tick(2 * BIT0);

    // Overrun with stalled consumer
    ready_i = 1'b0;
    o0 = ov_cnt;
    exp_q.push_back(8'h55);
    send_byte(8'h55, 1'b1, BIT0);
    send_byte(8'hAA, 1'b1, BIT0);
    tick(2 * BIT0);
    check("ovr_count", ov_cnt - o0, 1);
    check("ovr_data_held", int'(data_o), 8'h55);
    check("ovr_valid_held", int'(data_valid_o), 1);
    ready_i = 1'b1;
    tick(1);
    check("valid_clear_after_ready", int'(data_valid_o), 0);
    tick(BIT0);

    // Reset during bit 3 of 0xFF aborts silently
    f0 = fe_cnt; o0 = ov_cnt; v0 = vcyc;
    rxd_i = 1'b0;
    tick(BIT0);
    rxd_i = 1'b1;
    tick(3 * BIT0 + BIT0 / 2);
    rst_i = 1'b1;
    tick(1);
    rst_i = 1'b0;
    tick(1);
    check_quiet("midreset");
    tick(6 * BIT0);
    check("midreset_no_ferr", fe_cnt - f0, 0);
    check("midreset_no_ovr", ov_cnt - o0, 0);
    check("midreset_no_valid", vcyc - v0, 0);
    exp_q.push_back(8'h3C);
    send_byte(8'h3C, 1'b1, BIT0);
    tick(2 * BIT0);

    // Slowest rate, with rate_i flipped mid-frame
    rate_i = 2'd3;
    tick(4);
    exp_q.push_back(8'hC3);
    fork
      send_byte(8'hC3, 1'b1, BIT3);
      begin
        tick(4 * BIT3);
        rate_i = 2'd0;
      end
    join
    tick(2 * BIT3);

    check("scoreboard_drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
